// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage between execute and write-back.
//   Issues at most one data-memory request per instruction (addr/data
//   handshake), aligns and extends load data, and registers the result with
//   the pass-through control and exception fields for write-back.
// Parameter: PC_RESET - reset value of pc_out.
// Optional feature macro: MEM_FWD_EN - drives the forwarding bus fwd_bus;
//   when undefined fwd_bus is tied to zero.
// Ports:
//   clk, rst                         clock, asynchronous active-high reset
//   in_valid/in_ready                execute-side handshake
//   out_valid/out_ready              write-back handshake (out_valid registered)
//   ex_flush, ertn_flush, next_flush flush indications from write-back
//   this_flush                       this stage holds a flushing instruction
//   pc, result, mem_op, gr_we, dest, rkd_value, md_ctrl, exc_in  execute payload
//   data_req/wr/size/wstrb/addr/wdata, data_addr_ok/data_ok/rdata  memory bus
//   pc_out, result_out, gr_we_out, dest_out, md_ctrl_out, exc_out  registered payload
//   fwd_bus                          {busy, valid, dest[4:0], data[31:0]}
module mem_stage #(
  parameter logic [31:0] PC_RESET = 32'h1c000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        out_valid,
  input  logic        out_ready,
  input  logic        ex_flush,
  input  logic        ertn_flush,
  input  logic        next_flush,
  output logic        this_flush,
  input  logic [31:0] pc,
  input  logic [31:0] result,
  input  logic [7:0]  mem_op,
  input  logic        gr_we,
  input  logic [4:0]  dest,
  input  logic [31:0] rkd_value,
  input  logic [8:0]  md_ctrl,
  input  logic [49:0] exc_in,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [3:0]  data_wstrb,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata,
  output logic [31:0] pc_out,
  output logic [31:0] result_out,
  output logic        gr_we_out,
  output logic [4:0]  dest_out,
  output logic [8:0]  md_ctrl_out,
  output logic [49:0] exc_out,
  output logic [38:0] fwd_bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_buf;

  logic        w_acc, w_ld, w_st;
  logic        w_has_exc, w_ertn, w_wb_flush, w_kill;
  logic        w_ready_go, w_load_en;
  logic [31:0] w_raw, w_ld_value, w_final;

  // mem_op bits: 0 ld.b, 1 ld.h, 2 ld.w, 3 ld.bu, 4 ld.hu; off = addr[1:0]
  function automatic logic [31:0] load_extend(input logic [7:0]  op,
                                              input logic [1:0]  off,
                                              input logic [31:0] raw);
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'd0:    b = raw[7:0];
      2'd1:    b = raw[15:8];
      2'd2:    b = raw[23:16];
      default: b = raw[31:24];
    endcase
    h = off[1] ? raw[31:16] : raw[15:0];
    if (op[0])      load_extend = {{24{b[7]}}, b};
    else if (op[3]) load_extend = {24'd0, b};
    else if (op[1]) load_extend = {{16{h[15]}}, h};
    else if (op[4]) load_extend = {16'd0, h};
    else            load_extend = raw;
  endfunction

  assign w_acc      = |mem_op;
  assign w_ld       = |mem_op[4:0];
  assign w_st       = |mem_op[7:5];
  assign w_has_exc  = exc_in[47];
  assign w_ertn     = exc_in[48];
  assign w_wb_flush = ex_flush | ertn_flush;
  assign w_kill     = w_has_exc | w_ertn | next_flush | w_wb_flush;
  assign this_flush = in_valid & (w_has_exc | w_ertn | next_flush);

  assign data_req   = (r_state == S_IDLE) & in_valid & w_acc & !w_kill;
  assign data_wr    = w_st;
  assign data_addr  = result;

  // Killed and non-memory instructions never wait on the bus.
  assign w_ready_go = !in_valid | w_kill | !w_acc
                    | ((r_state == S_WAIT) & data_data_ok)
                    | (r_state == S_HOLD);
  assign in_ready   = (r_state != S_DRAIN) & (!in_valid | (w_ready_go & out_ready));
  assign w_load_en  = in_valid & w_ready_go & out_ready;

  // Once stalled, the response lives in r_buf; the bus may have moved on.
  assign w_raw      = (r_state == S_HOLD) ? r_buf : data_rdata;
  assign w_ld_value = load_extend(mem_op, result[1:0], w_raw);
  assign w_final    = w_ld ? w_ld_value : result;

  // Request size, byte strobes and replicated store data
  always_comb begin
    data_size  = 2'd0;
    data_wstrb = 4'h0;
    data_wdata = rkd_value;
    if (mem_op[7]) begin
      data_size  = 2'd2;
      data_wstrb = 4'hf;
    end else if (mem_op[6]) begin
      data_size  = 2'd1;
      data_wstrb = result[1] ? 4'b1100 : 4'b0011;
      data_wdata = {2{rkd_value[15:0]}};
    end else if (mem_op[5]) begin
      data_size  = 2'd0;
      data_wstrb = 4'b0001 << result[1:0];
      data_wdata = {4{rkd_value[7:0]}};
    end else if (mem_op[2]) begin
      data_size  = 2'd2;
    end else if (mem_op[1] | mem_op[4]) begin
      data_size  = 2'd1;
    end else begin
      data_size  = 2'd0;
    end
  end

  // Access FSM next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (data_req & data_addr_ok) w_state_nxt = S_WAIT;
        else                         w_state_nxt = S_IDLE;
      end
      S_WAIT: begin
        if (data_data_ok) begin
          if (out_ready | w_wb_flush) w_state_nxt = S_IDLE;
          else                        w_state_nxt = S_HOLD;
        end else if (w_wb_flush) begin
          w_state_nxt = S_DRAIN;
        end else begin
          w_state_nxt = S_WAIT;
        end
      end
      S_HOLD: begin
        if (out_ready | w_wb_flush) w_state_nxt = S_IDLE;
        else                        w_state_nxt = S_HOLD;
      end
      S_DRAIN: begin
        if (data_data_ok) w_state_nxt = S_IDLE;
        else              w_state_nxt = S_DRAIN;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Access FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Response buffer, filled only on the WAIT -> HOLD transition
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_buf <= 32'd0;
    else if ((r_state == S_WAIT) & data_data_ok & !out_ready & !w_wb_flush)
      r_buf <= data_rdata;
  end

  // Write-back valid; frozen while write-back stalls
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      out_valid <= 1'b0;
    else if (out_ready)
      out_valid <= in_valid & w_ready_go & !w_wb_flush;
  end

  // Write-back payload registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_out      <= PC_RESET;
      result_out  <= 32'd0;
      gr_we_out   <= 1'b0;
      dest_out    <= 5'd0;
      md_ctrl_out <= 9'd0;
      exc_out     <= 50'd0;
    end else if (w_load_en) begin
      pc_out      <= pc;
      result_out  <= w_final;
      gr_we_out   <= gr_we;
      dest_out    <= dest;
      md_ctrl_out <= md_ctrl;
      exc_out     <= exc_in;
    end
  end

`ifdef MEM_FWD_EN
  logic w_fwd_valid, w_fwd_busy;
  // md_ctrl[8] = res_from_div, md_ctrl[7] = res_from_mul
  assign w_fwd_valid = in_valid & gr_we & (dest != 5'd0);
  assign w_fwd_busy  = w_fwd_valid & ((w_ld & !w_ready_go) | md_ctrl[7] | md_ctrl[8]);
  assign fwd_bus     = {w_fwd_busy, w_fwd_valid, dest, (w_ready_go ? w_final : result)};
`else
  assign fwd_bus = 39'd0;
`endif

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

  localparam logic [31:0] PC_RST = 32'h1c000000;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic        ex_flush, ertn_flush, next_flush, this_flush;
  logic [31:0] pc, result, rkd_value;
  logic [7:0]  mem_op;
  logic        gr_we;
  logic [4:0]  dest;
  logic [8:0]  md_ctrl;
  logic [49:0] exc_in;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr, data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic [31:0] pc_out, result_out;
  logic        gr_we_out;
  logic [4:0]  dest_out;
  logic [8:0]  md_ctrl_out;
  logic [49:0] exc_out;
  logic [38:0] fwd_bus;

  mem_stage #(.PC_RESET(PC_RST)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .ex_flush(ex_flush), .ertn_flush(ertn_flush), .next_flush(next_flush),
    .this_flush(this_flush),
    .pc(pc), .result(result), .mem_op(mem_op), .gr_we(gr_we), .dest(dest),
    .rkd_value(rkd_value), .md_ctrl(md_ctrl), .exc_in(exc_in),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .pc_out(pc_out), .result_out(result_out), .gr_we_out(gr_we_out),
    .dest_out(dest_out), .md_ctrl_out(md_ctrl_out), .exc_out(exc_out),
    .fwd_bus(fwd_bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] res;
    logic        we;
    logic [4:0]  dest;
    logic [8:0]  md;
    logic [49:0] exc;
  } wb_t;

  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
  } rq_t;

  typedef struct packed {
    logic [7:0]  op;
    logic [31:0] addr;
    logic [31:0] rkd;
    logic [31:0] rdata;
    int          adly;
    int          ddly;
    int          hold;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic [31:0] res;
  } vec_t;

  wb_t  wb_q[$];
  rq_t  rq_q[$];
  vec_t vecs[9];
  int   n_total = 0;
  int   n_pass  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Scoreboard monitor: write-back outputs and accepted memory requests
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        if (wb_q.size() == 0) begin
          n_total++;
          $display("FAIL wb_unexpected: got output pc %h expected no output", pc_out);
        end else begin
          wb_t e;
          e = wb_q.pop_front();
          chk("wb_pc", {32'd0, pc_out}, {32'd0, e.pc});
          chk("wb_result", {32'd0, result_out}, {32'd0, e.res});
          chk("wb_gr_we", {63'd0, gr_we_out}, {63'd0, e.we});
          chk("wb_dest", {59'd0, dest_out}, {59'd0, e.dest});
          chk("wb_md_ctrl", {55'd0, md_ctrl_out}, {55'd0, e.md});
          chk("wb_exc", {14'd0, exc_out}, {14'd0, e.exc});
        end
      end
      if (data_req && data_addr_ok) begin
        if (rq_q.size() == 0) begin
          n_total++;
          $display("FAIL rq_unexpected: got request addr %h expected no request", data_addr);
        end else begin
          rq_t r;
          r = rq_q.pop_front();
          chk("rq_wr", {63'd0, data_wr}, {63'd0, r.wr});
          chk("rq_size", {62'd0, data_size}, {62'd0, r.size});
          chk("rq_wstrb", {60'd0, data_wstrb}, {60'd0, r.wstrb});
          chk("rq_addr", {32'd0, data_addr}, {32'd0, r.addr});
          if (r.wr) chk("rq_wdata", {32'd0, data_wdata}, {32'd0, r.wdata});
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] a_pc, input logic [31:0] a_res, input logic [7:0] op,
                       input logic we, input logic [4:0] dst, input logic [31:0] rkd,
                       input logic [8:0] md, input logic [49:0] exc);
    in_valid = 1'b1; pc = a_pc; result = a_res; mem_op = op; gr_we = we;
    dest = dst; rkd_value = rkd; md_ctrl = md; exc_in = exc;
  endtask

  task automatic push_wb(input logic [31:0] a_pc, input logic [31:0] a_res, input logic we,
                         input logic [4:0] dst, input logic [8:0] md, input logic [49:0] exc);
    wb_t e;
    e.pc = a_pc; e.res = a_res; e.we = we; e.dest = dst; e.md = md; e.exc = exc;
    wb_q.push_back(e);
  endtask

  task automatic push_rq(input logic wr, input logic [1:0] size, input logic [3:0] wstrb,
                         input logic [31:0] addr, input logic [31:0] wdata);
    rq_t r;
    r.wr = wr; r.size = size; r.wstrb = wstrb; r.addr = addr; r.wdata = wdata;
    rq_q.push_back(r);
  endtask

  task automatic alu(input logic [31:0] a_pc, input logic [31:0] a_res, input logic we,
                     input logic [4:0] dst, input logic [8:0] md);
    logic [38:0] exp_fwd;
    logic        fv;
    push_wb(a_pc, a_res, we, dst, md, 50'd0);
    drive(a_pc, a_res, 8'd0, we, dst, 32'h0, md, 50'd0);
    fv = we & (dst != 5'd0);
`ifdef MEM_FWD_EN
    exp_fwd = {fv & (md[7] | md[8]), fv, dst, a_res};
`else
    exp_fwd = 39'd0;
`endif
    #1;
    chk("alu_no_req", {63'd0, data_req}, 64'd0);
    chk("alu_in_ready", {63'd0, in_ready}, 64'd1);
    chk("alu_fwd_bus", {25'd0, fwd_bus}, {25'd0, exp_fwd});
    tick();
    chk("alu_out_valid", {63'd0, out_valid}, 64'd1);
    in_valid = 1'b0;
  endtask

  task automatic mem_access(input vec_t v, input logic [31:0] a_pc);
    logic we;
    we = |v.op[4:0];
    push_rq(|v.op[7:5], v.size, v.wstrb, v.addr, v.wdata);
    push_wb(a_pc, v.res, we, 5'd9, 9'd0, 50'd0);
    drive(a_pc, v.addr, v.op, we, 5'd9, v.rkd, 9'd0, 50'd0);
    #1;
    chk("issue_in_ready", {63'd0, in_ready}, 64'd0);
    chk("issue_req", {63'd0, data_req}, 64'd1);
    for (int i = 0; i < v.adly; i++) tick();
    data_addr_ok = 1'b1;
    tick();
    data_addr_ok = 1'b0;
    for (int i = 1; i < v.ddly; i++) begin
      #1;
      chk("wait_in_ready", {63'd0, in_ready}, 64'd0);
      chk("wait_no_req", {63'd0, data_req}, 64'd0);
      tick();
    end
    data_data_ok = 1'b1;
    data_rdata   = v.rdata;
    if (v.hold > 0) out_ready = 1'b0;
    #1;
    chk("dok_in_ready", {63'd0, in_ready}, (v.hold > 0) ? 64'd0 : 64'd1);
    tick();
    data_data_ok = 1'b0;
    data_rdata   = 32'hdeadbeef;
    if (v.hold > 0) begin
      for (int i = 1; i < v.hold; i++) begin
        #1;
        chk("hold_out_valid", {63'd0, out_valid}, 64'd0);
        chk("hold_no_req", {63'd0, data_req}, 64'd0);
        tick();
      end
      out_ready = 1'b1;
      #1;
      chk("hold_in_ready", {63'd0, in_ready}, 64'd1);
      tick();
    end
    in_valid = 1'b0;
    mem_op   = 8'd0;
  endtask

  function automatic vec_t mk(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] rkd,
                              input logic [31:0] rdata, input int adly, input int ddly, input int hold,
                              input logic [1:0] size, input logic [3:0] wstrb,
                              input logic [31:0] wdata, input logic [31:0] res);
    vec_t v;
    v.op = op; v.addr = addr; v.rkd = rkd; v.rdata = rdata; v.adly = adly; v.ddly = ddly;
    v.hold = hold; v.size = size; v.wstrb = wstrb; v.wdata = wdata; v.res = res;
    return v;
  endfunction

  initial begin
    //            op     addr          rkd           rdata         ad dd hd sz wstrb    wdata         result
    vecs[0] = mk(8'h01, 32'h1c000003, 32'h0,        32'h80aabbcc, 1, 2, 0, 2'd0, 4'b0000, 32'h0,        32'hffffff80);
    vecs[1] = mk(8'h40, 32'h1c000022, 32'h0000beef, 32'h0,        0, 1, 0, 2'd1, 4'b1100, 32'hbeefbeef, 32'h1c000022);
    vecs[2] = mk(8'h20, 32'h1c000021, 32'h12345677, 32'h0,        0, 1, 0, 2'd0, 4'b0010, 32'h77777777, 32'h1c000021);
    vecs[3] = mk(8'h80, 32'h1c000024, 32'hcafef00d, 32'h0,        2, 3, 0, 2'd2, 4'b1111, 32'hcafef00d, 32'h1c000024);
    vecs[4] = mk(8'h10, 32'h1c000102, 32'h0,        32'habcd1234, 0, 1, 3, 2'd1, 4'b0000, 32'h0,        32'h0000abcd);
    vecs[5] = mk(8'h02, 32'h1c000100, 32'h0,        32'h12348001, 0, 1, 0, 2'd1, 4'b0000, 32'h0,        32'hffff8001);
    vecs[6] = mk(8'h08, 32'h1c000101, 32'h0,        32'h0000f500, 0, 1, 0, 2'd0, 4'b0000, 32'h0,        32'h000000f5);
    vecs[7] = mk(8'h04, 32'h1c000104, 32'h0,        32'h89abcdef, 1, 1, 0, 2'd2, 4'b0000, 32'h0,        32'h89abcdef);
    vecs[8] = mk(8'h01, 32'h1c000102, 32'h0,        32'h007f0000, 0, 2, 0, 2'd0, 4'b0000, 32'h0,        32'h0000007f);

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    ex_flush = 1'b0; ertn_flush = 1'b0; next_flush = 1'b0;
    pc = 32'h0; result = 32'h0; mem_op = 8'h0; gr_we = 1'b0; dest = 5'd0;
    rkd_value = 32'h0; md_ctrl = 9'h0; exc_in = 50'd0;
    data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'h0;

    repeat (3) tick();
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_pc_out", {32'd0, pc_out}, {32'd0, PC_RST});
    chk("rst_result_out", {32'd0, result_out}, 64'd0);
    chk("rst_exc_out", {14'd0, exc_out}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_this_flush", {63'd0, this_flush}, 64'd0);
    rst = 1'b0;
    tick();

    // non-memory instructions, single cycle
    alu(32'h1c000010, 32'h12345678, 1'b1, 5'd5, 9'h000);
    alu(32'h1c000014, 32'h0f0f0f0f, 1'b0, 5'd0, 9'h1a5);
    tick();

    // directed load/store vectors
    for (int i = 0; i < 9; i++) mem_access(vecs[i], 32'h1c001000 + 32'(4 * i));
    tick();

    // ex_flush while a load is outstanding: response must be drained
    push_rq(1'b0, 2'd2, 4'b0000, 32'h1c000200, 32'h0);
    drive(32'h1c002000, 32'h1c000200, 8'h04, 1'b1, 5'd3, 32'h0, 9'h0, 50'd0);
    data_addr_ok = 1'b1;
    tick();
    data_addr_ok = 1'b0;
    ex_flush = 1'b1;
    tick();
    ex_flush = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("drain_out_valid", {63'd0, out_valid}, 64'd0);
    drive(32'h1c002004, 32'h1c000208, 8'h04, 1'b1, 5'd9, 32'h0, 9'h0, 50'd0);
    #1;
    chk("drain_in_ready", {63'd0, in_ready}, 64'd0);
    chk("drain_no_req", {63'd0, data_req}, 64'd0);
    tick();
    chk("drain2_in_ready", {63'd0, in_ready}, 64'd0);
    chk("drain2_no_req", {63'd0, data_req}, 64'd0);
    data_data_ok = 1'b1;
    data_rdata   = 32'hbad0bad0;
    #1;
    chk("drain_dok_in_ready", {63'd0, in_ready}, 64'd0);
    tick();
    data_data_ok = 1'b0;
    chk("drain_end_out_valid", {63'd0, out_valid}, 64'd0);
    mem_access(mk(8'h04, 32'h1c000208, 32'h0, 32'h55aa33cc, 0, 1, 0, 2'd2, 4'b0000, 32'h0, 32'h55aa33cc),
               32'h1c002004);
    tick();

    // exception-tagged ld.w: no request, flushes, payload copied (load data path still selected)
    data_rdata = 32'h13572468;
    push_wb(32'h1c000300, 32'h13572468, 1'b1, 5'd4, 9'h0,
            {1'b0, 1'b0, 1'b1, 6'h0a, 9'h003, 32'h1c000305});
    drive(32'h1c000300, 32'h1c000305, 8'h04, 1'b1, 5'd4, 32'h0, 9'h0,
          {1'b0, 1'b0, 1'b1, 6'h0a, 9'h003, 32'h1c000305});
    #1;
    chk("exc_this_flush", {63'd0, this_flush}, 64'd1);
    chk("exc_no_req", {63'd0, data_req}, 64'd0);
    chk("exc_in_ready", {63'd0, in_ready}, 64'd1);
    tick();
    in_valid = 1'b0;
    exc_in   = 50'd0;

    // next_flush suppresses a store
    push_wb(32'h1c000304, 32'h1c000310, 1'b0, 5'd0, 9'h0, 50'd0);
    drive(32'h1c000304, 32'h1c000310, 8'h80, 1'b0, 5'd0, 32'h11111111, 9'h0, 50'd0);
    next_flush = 1'b1;
    #1;
    chk("nf_this_flush", {63'd0, this_flush}, 64'd1);
    chk("nf_no_req", {63'd0, data_req}, 64'd0);
    tick();
    next_flush = 1'b0;
    in_valid   = 1'b0;
    tick();

    // async reset while WAIT, then a stale data_ok must be ignored
    push_rq(1'b0, 2'd2, 4'b0000, 32'h1c000400, 32'h0);
    drive(32'h1c000400, 32'h1c000400, 8'h04, 1'b1, 5'd6, 32'h0, 9'h0, 50'd0);
    data_addr_ok = 1'b1;
    tick();
    data_addr_ok = 1'b0;
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("arst_pc_out", {32'd0, pc_out}, {32'd0, PC_RST});
    chk("arst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("arst_result_out", {32'd0, result_out}, 64'd0);
    tick();
    rst = 1'b0;
    drive(32'h1c000500, 32'h1c000504, 8'h04, 1'b1, 5'd9, 32'h0, 9'h0, 50'd0);
    data_data_ok = 1'b1;
    data_rdata   = 32'hfeedface;
    #1;
    chk("post_rst_req", {63'd0, data_req}, 64'd1);
    chk("post_rst_in_ready", {63'd0, in_ready}, 64'd0);
    tick();
    data_data_ok = 1'b0;
    mem_access(mk(8'h04, 32'h1c000504, 32'h0, 32'h24681357, 0, 2, 0, 2'd2, 4'b0000, 32'h0, 32'h24681357),
               32'h1c000500);

    for (int i = 0; i < 50 && (wb_q.size() != 0 || rq_q.size() != 0); i++) tick();
    chk("wb_queue_drained", 64'(wb_q.size()), 64'd0);
    chk("rq_queue_drained", 64'(rq_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
